// File: rtl/count8_arb_if.sv
// Bundle between the timing clients, the round-robin scheduler and the shared 8-bit counter.
// The scheduler takes the slave view; the clients and the counter take the master view.
interface count8_arb_if;
   logic [1:0] req;
   logic [7:0] dur0;
   logic [7:0] dur1;
   logic [1:0] gnt;
   logic [1:0] done;
   logic       busy;
   logic       cnt_load;
   logic       cnt_en;
   logic [7:0] cnt_in;
   logic [7:0] cnt;

   modport slave (
      input  req, dur0, dur1, cnt,
      output gnt, done, busy, cnt_load, cnt_en, cnt_in
   );

   modport master (
      output req, dur0, dur1, cnt,
      input  gnt, done, busy, cnt_load, cnt_en, cnt_in
   );
endinterface

// File: rtl/count8_arb.sv
// Two-requester round-robin scheduler for one shared loadable 8-bit up-counter.
// Each grant clears the counter, then enables it for the granted duration and pulses done.
module count8_arb (
   input  logic        clk,
   input  logic        res,
   count8_arb_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t     state_q;
   logic [1:0] gnt_q;
   logic [1:0] done_q;
   logic       prio_q;
   logic       owner_q;
   logic [7:0] dur_q;

   logic       req_any;
   logic       winner;
   logic [7:0] win_dur;
   logic [7:0] dur_m1;
   logic       run_last;

   function automatic logic [1:0] onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

   // On contention the requester indexed by prio wins; a lone request always wins.
   always_comb begin
      req_any  = |bus.req;
      winner   = (bus.req == 2'b11) ? prio_q : bus.req[1];
      win_dur  = winner ? bus.dur1 : bus.dur0;
      dur_m1   = dur_q - 8'd1;
      run_last = (bus.cnt == dur_m1);
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state_q <= IDLE;
         gnt_q   <= 2'b00;
         done_q  <= 2'b00;
         prio_q  <= 1'b0;
         owner_q <= 1'b0;
         dur_q   <= 8'h00;
      end else begin
         case (state_q)
            IDLE: begin
               gnt_q  <= 2'b00;
               done_q <= 2'b00;
               if (req_any) begin
                  owner_q <= winner;
                  dur_q   <= win_dur;
                  gnt_q   <= onehot(winner);
                  prio_q  <= ~winner;
                  // A zero duration skips the counter entirely and completes at once.
                  if (win_dur != 8'h00) begin
                     state_q <= LOAD;
                  end else begin
                     state_q <= DONE;
                     done_q  <= onehot(winner);
                  end
               end
            end
            LOAD: begin
               state_q <= RUN;
            end
            RUN: begin
               // Counter holds j-1 in the j-th RUN cycle, so dur_q-1 marks the last one.
               if (run_last) begin
                  state_q <= DONE;
                  done_q  <= onehot(owner_q);
               end
            end
            DONE: begin
               state_q <= IDLE;
               gnt_q   <= 2'b00;
               done_q  <= 2'b00;
            end
            default: begin
               state_q <= IDLE;
               gnt_q   <= 2'b00;
               done_q  <= 2'b00;
            end
         endcase
      end
   end

   assign bus.gnt      = gnt_q;
   assign bus.done     = done_q;
   assign bus.busy     = (state_q != IDLE);
   assign bus.cnt_load = (state_q == LOAD);
   assign bus.cnt_en   = (state_q == RUN);
   assign bus.cnt_in   = 8'h00;

endmodule

// File: tb/tb_count8_arb.sv
// Directed bench for count8_arb with a behavioural model of the shared counter.
module tb_count8_arb;

   logic clk = 1'b0;
   logic res = 1'b1;
   logic [7:0] cnt_m = 8'h00;
   int total = 0;
   int bad = 0;
   int excl_err = 0;

   count8_arb_if bus ();

   count8_arb dut (
      .clk (clk),
      .res (res),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Shared counter: load has priority over enable.
   always @(posedge clk) begin
      if (bus.cnt_load)
         cnt_m <= bus.cnt_in;
      else if (bus.cnt_en)
         cnt_m <= cnt_m + 8'd1;
   end
   assign bus.cnt = cnt_m;

   always @(negedge clk) begin
      if (bus.cnt_load && bus.cnt_en)
         excl_err++;
   end

   typedef struct {
      logic [1:0] req;
      logic [7:0] d0;
      logic [7:0] d1;
      logic [1:0] gnt;
      logic [1:0] done;
      logic       busy;
      logic       load;
      logic       en;
      logic       chk_cnt;
      logic [7:0] cnt;
   } vec_t;

   vec_t vt[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s = %0h", name, act);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int ncyc;
      int en_cnt;
      int ndone;
      int last_t;
      logic [1:0] dseq[4];
      logic [1:0] gseq[4];
      int dt[4];
      logic [7:0] cnt_at_done;
      logic got_done;

      // Single request dur0=3, then zero-duration request from requester 1.
      vt[0] = '{2'b01, 8'd3, 8'd0, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
      vt[1] = '{2'b00, 8'd0, 8'd0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00};
      vt[2] = '{2'b00, 8'd0, 8'd0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01};
      vt[3] = '{2'b00, 8'd0, 8'd0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h02};
      vt[4] = '{2'b00, 8'd0, 8'd0, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 8'h03};
      vt[5] = '{2'b00, 8'd0, 8'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h03};
      vt[6] = '{2'b10, 8'd9, 8'd0, 2'b10, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 8'h03};
      vt[7] = '{2'b00, 8'd0, 8'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h03};

      bus.req  = 2'b00;
      bus.dur0 = 8'd0;
      bus.dur1 = 8'd0;

      // Reset state
      #2;
      check("rst_gnt", bus.gnt, 2'b00);
      check("rst_done", bus.done, 2'b00);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_load", bus.cnt_load, 1'b0);
      check("rst_en", bus.cnt_en, 1'b0);
      check("rst_cnt_in", bus.cnt_in, 8'h00);
      step();
      step();
      res = 1'b0;

      // Reset mid-run: assert res in the 4th RUN cycle
      bus.req = 2'b01; bus.dur0 = 8'd10;
      step();
      bus.req = 2'b00;
      check("mr_load", bus.cnt_load, 1'b1);
      step(); step(); step(); step();
      check("mr_run4_en", bus.cnt_en, 1'b1);
      #2 res = 1'b1;
      #1;
      check("mr_gnt", bus.gnt, 2'b00);
      check("mr_busy", bus.busy, 1'b0);
      check("mr_en", bus.cnt_en, 1'b0);
      check("mr_done", bus.done, 2'b00);
      @(negedge clk);
      res = 1'b0;
      step(); step();
      check("mr_idle_busy", bus.busy, 1'b0);
      check("mr_idle_gnt", bus.gnt, 2'b00);

      // Table-driven single-request and zero-duration sequence
      for (int i = 0; i < 8; i++) begin
         bus.req = vt[i].req; bus.dur0 = vt[i].d0; bus.dur1 = vt[i].d1;
         step();
         check($sformatf("v%0d_gnt", i), bus.gnt, vt[i].gnt);
         check($sformatf("v%0d_done", i), bus.done, vt[i].done);
         check($sformatf("v%0d_busy", i), bus.busy, vt[i].busy);
         check($sformatf("v%0d_load", i), bus.cnt_load, vt[i].load);
         check($sformatf("v%0d_en", i), bus.cnt_en, vt[i].en);
         if (vt[i].chk_cnt)
            check($sformatf("v%0d_cnt", i), bus.cnt, vt[i].cnt);
      end

      // Contention: req=11 held, dur0=2, dur1=5
      bus.req = 2'b11; bus.dur0 = 8'd2; bus.dur1 = 8'd5;
      ndone = 0; last_t = 0;
      for (int c = 0; c < 100 && ndone < 4; c++) begin
         step();
         if (bus.done != 2'b00) begin
            dseq[ndone] = bus.done;
            gseq[ndone] = bus.gnt;
            dt[ndone] = c - last_t;
            last_t = c;
            ndone++;
            if (ndone == 4) bus.req = 2'b00;
         end
      end
      check("ct_ndone", ndone, 4);
      if (ndone == 4) begin
         check("ct_done0", dseq[0], 2'b01);
         check("ct_done1", dseq[1], 2'b10);
         check("ct_done2", dseq[2], 2'b01);
         check("ct_done3", dseq[3], 2'b10);
         check("ct_gnt1", gseq[1], 2'b10);
         check("ct_gnt2", gseq[2], 2'b01);
         check("ct_gap1", dt[1], 8);
         check("ct_gap2", dt[2], 5);
         check("ct_gap3", dt[3], 8);
      end
      step(); step();
      check("ct_idle", bus.busy, 1'b0);

      // Maximum duration 255
      bus.req = 2'b01; bus.dur0 = 8'd255;
      step();
      bus.req = 2'b00; bus.dur0 = 8'd0;
      en_cnt = 0; got_done = 1'b0; cnt_at_done = 8'h00;
      for (int c = 0; c < 400 && !got_done; c++) begin
         step();
         if (bus.cnt_en) en_cnt++;
         if (bus.done != 2'b00) begin
            got_done = 1'b1;
            cnt_at_done = bus.cnt;
            check("max_done", bus.done, 2'b01);
            check("max_gnt", bus.gnt, 2'b01);
         end
      end
      check("max_got_done", got_done, 1'b1);
      check("max_en_cycles", en_cnt, 255);
      check("max_cnt", cnt_at_done, 8'hFF);
      step();

      // Dropped request: req0 for one cycle, req1 pending afterwards
      bus.req = 2'b01; bus.dur0 = 8'd4; bus.dur1 = 8'd1;
      step();
      ncyc = 1;
      check("dr_gnt_k1", bus.gnt, 2'b01);
      bus.req = 2'b10; bus.dur0 = 8'd0;
      while (ncyc < 6) begin step(); ncyc++; end
      check("dr_done_k6", bus.done, 2'b01);
      check("dr_cnt_k6", bus.cnt, 8'h04);
      step(); step();
      check("dr_next_gnt", bus.gnt, 2'b10);
      bus.req = 2'b00;
      step(); step(); step(); step();

      check("excl_load_en", excl_err, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/count8_arb.md
# count8_arb

Two-requester round-robin scheduler for one shared 8-bit loadable up-counter. It grants the counter to one requester at a time and clears it through the load port. It then enables counting for exactly the requested number of cycles and pulses a per-requester done flag. The block sits between the timing clients and the counter instance, and drives every control input of that counter.

## Interface
- No parameters; counter width is fixed at 8 bits and requester count at 2.
- clk  input  1  system clock; all state changes on rising edge.
- res  input  1  asynchronous, active-high reset.
- req  input  2  request per requester; only sampled in IDLE.
- dur0  input  8  duration for requester 0 in cycles; sampled with its grant.
- dur1  input  8  duration for requester 1 in cycles; sampled with its grant.
- gnt  output  2  one-hot grant, registered; 2'b00 when idle.
- done  output  2  one-cycle completion pulse for the granted requester, registered.
- busy  output  1  high in any state other than IDLE.
- cnt_load  output  1  drives the counter's load input.
- cnt_en  output  1  drives the counter's enable input.
- cnt_in  output  8  drives the counter's parallel-load data; constant 8'h00.
- cnt  input  8  current counter value, fed back from the counter output.

## Operation
- Reset state: FSM IDLE, gnt=00, done=00, busy=0, cnt_load=0, cnt_en=0, prio=0 (requester 0 favoured), dur_q=0, owner=0.
- States are IDLE, LOAD, RUN and DONE.
- **IDLE:**
  - With req=00, remain in IDLE.
  - With exactly one req bit set, that requester wins.
  - With req=11, the requester indexed by prio wins.
  - On a win: owner<=winner, dur_q<=dur[winner], gnt<=onehot(winner), prio<=~winner.
  - Next state is LOAD if dur[winner]!=0, otherwise DONE.
- **LOAD:** cnt_load=1, cnt_en=0, cnt_in=8'h00. The counter holds 0 after this edge. Next state is RUN.
- **RUN:** cnt_en=1, cnt_load=0. When cnt==dur_q-1 (8-bit compare), the next state is DONE. Otherwise the FSM stays in RUN.
- **DONE:** cnt_en=0, cnt_load=0, done[owner]=1, gnt unchanged. Next state is IDLE, where gnt<=00.
- Arithmetic: dur_q-1 is computed modulo 256. The dur_q=0 path never reaches RUN, so there is no underflow compare. The counter finishes at value dur_q and never wraps.
- Once a request has been granted, deasserting req has no effect; there is no abort. A new req is not accepted until the FSM returns to IDLE.
- dur inputs are ignored outside the IDLE grant edge.
- cnt_load and cnt_en are never high in the same cycle.
- The controller relies only on equality with cnt. The counter must not be loaded or reset by other agents while busy=1; if it is, the equality may be missed, and this is out of contract.
- Asserting res in any state returns the block to the full reset state asynchronously. The grant is dropped, no done pulse is issued, and the counter contents are left untouched.

## Timing
- A request sampled high at IDLE edge k asserts gnt and LOAD in cycle k+1.
- RUN occupies cycles k+2 .. k+1+dur; cnt_en is high for exactly dur cycles.
- DONE is in cycle k+2+dur.
- Total grant length is dur+2 cycles. For dur=0, the grant lasts 1 cycle and coincides with done.
- There is at least one IDLE cycle between consecutive grants, so back-to-back service has a period of dur+3 cycles.
- done is high for exactly one cycle and is always accompanied by the matching gnt bit.
- All outputs are registered or decoded from state only; no input-to-output combinational path exists.

## Test plan
- **Reset mid-run:** req=01, dur0=10; raise res in the 4th RUN cycle. Required: gnt=00, busy=0, cnt_en=0 and done=00 immediately (asynchronous). After release with req=00, the block stays IDLE.
- **Single request:** req0 pulsed at edge k, dur0=3. Required:
  - gnt=01 over cycles k+1..k+5.
  - cnt_load=1 at k+1.
  - cnt_en=1 over k+2..k+4.
  - done=01 at k+5, with cnt=3 in DONE.
- **Contention:** req=11 held, dur0=2, dur1=5. Required: grant order 0,1,0,1. done pulses alternate 01,10, spaced 5 and 8 cycles apart.
- **Zero duration:** req=10, dur1=0. Required: gnt=10 and done=10 in the same single cycle, with cnt_load and cnt_en never asserted.
- **Maximum duration:** req=01, dur0=255. Required: cnt_en high for 255 cycles and cnt=8'hFF in DONE, with no wrap to 0.
- **Dropped request:** req0 deasserted one cycle after the grant, dur0=4. Required: the transaction completes with done=01 at k+6, and the next grant goes to requester 1 if req1 is pending.
